// File: rtl/icache_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | icache_ctrl_pkg: shared types and widths for the icache slice.  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package icache_ctrl_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } icache_state_t;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/icache_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | icache_ctrl_if: fill bus between the icache and instruction mem.|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface icache_ctrl_if;
   import icache_ctrl_pkg::*;

   logic              Icache2mem_req;
   logic [ADDR_W-1:0] Icache2mem_addr;
   logic              mem2Icache_ack;
   logic              mem2Icache_valid;
   logic [DATA_W-1:0] mem2Icache_data;

   modport master (
      output Icache2mem_req,
      output Icache2mem_addr,
      input  mem2Icache_ack,
      input  mem2Icache_valid,
      input  mem2Icache_data
   );

   modport slave (
      input  Icache2mem_req,
      input  Icache2mem_addr,
      output mem2Icache_ack,
      output mem2Icache_valid,
      output mem2Icache_data
   );
endinterface
`default_nettype wire

// File: rtl/icache_mem.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | icache_mem: flop-based tag/valid/data arrays, async read port.  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module icache_mem
   import icache_ctrl_pkg::*;
#(
   parameter  int NUM_LINES = 32,
   localparam int IDX_BITS  = $clog2(NUM_LINES),
   localparam int TAG_BITS  = ADDR_W - IDX_BITS - 2
) (
   input  wire logic                clk,
   input  wire logic                rst,
   input  wire logic                flush_all,
   input  wire logic [IDX_BITS-1:0] rd_idx,
   output logic                     rd_valid,
   output logic [TAG_BITS-1:0]      rd_tag,
   output logic [DATA_W-1:0]        rd_data,
   input  wire logic                wr_en,
   input  wire logic [IDX_BITS-1:0] wr_idx,
   input  wire logic [TAG_BITS-1:0] wr_tag,
   input  wire logic [DATA_W-1:0]   wr_data,
   input  wire logic                wr_valid
);

   logic [NUM_LINES-1:0] valid;
   logic [TAG_BITS-1:0]  tag_array  [NUM_LINES];
   logic [DATA_W-1:0]    data_array [NUM_LINES];

   // Flush outranks a fill write landing on the same edge.
   always_ff @(posedge clk) begin
      if (rst || flush_all) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= wr_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_array[wr_idx]  <= wr_tag;
         data_array[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tag_array[rd_idx];
   assign rd_data  = data_array[rd_idx];

endmodule
`default_nettype wire

// File: rtl/icache_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | icache_ctrl: direct-mapped one-word-line icache, miss fill FSM. |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module icache_ctrl
   import icache_ctrl_pkg::*;
#(
   parameter int NUM_LINES = 32
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic [ADDR_W-1:0] proc2Icache_addr,
   output logic [DATA_W-1:0]      Icache_data_out,
   output logic                   Icache_valid_out,
   input  wire logic              flush,
   icache_ctrl_if.master          mem,
   output logic [31:0]            miss_count
);

   localparam int IDX_BITS = $clog2(NUM_LINES);
   localparam int TAG_BITS = ADDR_W - IDX_BITS - 2;

   icache_state_t       state;
   icache_state_t       state_next;
   logic [ADDR_W-1:0]   fill_addr;
   logic                drop;
   logic                launch;
   logic                fill_we;
   logic                hit;
   logic                rd_valid;
   logic [TAG_BITS-1:0] rd_tag;
   logic [IDX_BITS-1:0] idx;
   logic [TAG_BITS-1:0] tag;
   logic                unused_addr_bits;

   assign idx = proc2Icache_addr[IDX_BITS+1:2];
   assign tag = proc2Icache_addr[ADDR_W-1:IDX_BITS+2];
   assign unused_addr_bits = ^{proc2Icache_addr[1:0], fill_addr[1:0]};

   icache_mem #(
      .NUM_LINES (NUM_LINES)
   ) u_mem (
      .clk       (clk),
      .rst       (rst),
      .flush_all (flush),
      .rd_idx    (idx),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_data   (Icache_data_out),
      .wr_en     (fill_we),
      .wr_idx    (fill_addr[IDX_BITS+1:2]),
      .wr_tag    (fill_addr[ADDR_W-1:IDX_BITS+2]),
      .wr_data   (mem.mem2Icache_data),
      .wr_valid  (!drop && !flush)
   );

   assign hit = rd_valid && (rd_tag == tag);

   // Gated by rst so nothing looks valid while reset is still asserted.
   assign Icache_valid_out    = hit && !rst;
   assign mem.Icache2mem_req  = (state == REQ) && !rst;
   assign mem.Icache2mem_addr = fill_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      launch     = 1'b0;
      fill_we    = 1'b0;
      unique case (state)
         IDLE: begin
            if (!hit && !flush) begin
               launch     = 1'b1;
               state_next = REQ;
            end
         end
         REQ: begin
            if (mem.mem2Icache_ack) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (mem.mem2Icache_valid) begin
               fill_we    = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // A flush while a fill is outstanding poisons that fill; it still lands but stays invalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_addr  <= '0;
         drop       <= 1'b0;
         miss_count <= '0;
      end else begin
         if (launch) begin
            fill_addr  <= word_align(proc2Icache_addr);
            miss_count <= miss_count + 32'd1;
         end
         if (fill_we) begin
            drop <= 1'b0;
         end else if (flush && (state != IDLE)) begin
            drop <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_icache_ctrl: directed + random fetch traffic vs line model.  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_icache_ctrl;

   localparam int NL = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = '0;
   logic        flush = 1'b0;
   logic [31:0] data_out;
   logic        valid_out;
   logic [31:0] miss_count;

   int n_vec = 0;
   int n_err = 0;

   // Reference: each line remembers which word address it holds.
   bit          m_valid     [NL];
   logic [31:0] m_line_addr [NL];
   logic [31:0] m_data      [NL];
   bit          busy, acked, dropped;
   logic [31:0] pend_addr;
   logic [31:0] m_misses;

   icache_ctrl_if bus ();

   icache_ctrl #(
      .NUM_LINES (NL)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .proc2Icache_addr (addr),
      .Icache_data_out  (data_out),
      .Icache_valid_out (valid_out),
      .flush            (flush),
      .mem              (bus),
      .miss_count       (miss_count)
   );

   always #10 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int line_of(input logic [31:0] a);
      return int'((a >> 2) % NL);
   endfunction

   function automatic bit model_hit(input logic [31:0] a);
      return m_valid[line_of(a)] && (m_line_addr[line_of(a)] == (a & ~32'd3));
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
      busy = 1'b0; acked = 1'b0; dropped = 1'b0;
      m_misses = '0;
   endtask

   // One cycle: drive, check against model, advance model, step to posedge+1.
   task automatic step(input logic [31:0] a, input bit f, input bit ak, input bit v, input logic [31:0] d);
      bit h;
      int j;
      addr = a; flush = f;
      bus.mem2Icache_ack = ak; bus.mem2Icache_valid = v; bus.mem2Icache_data = d;
      #2;
      h = model_hit(a);
      check_value("hit", {31'd0, valid_out}, {31'd0, h});
      if (h) check_value("data", data_out, m_data[line_of(a)]);
      check_value("req", {31'd0, bus.Icache2mem_req}, {31'd0, busy && !acked});
      if (busy && !acked) check_value("fill_addr", bus.Icache2mem_addr, pend_addr);
      check_value("miss_count", miss_count, m_misses);
      if (!busy) begin
         if (!h && !f) begin
            busy = 1'b1; acked = 1'b0; dropped = 1'b0;
            pend_addr = a & ~32'd3;
            m_misses = m_misses + 32'd1;
         end
      end else if (!acked) begin
         if (ak) acked = 1'b1;
         if (f) dropped = 1'b1;
      end else begin
         if (f) dropped = 1'b1;
         if (v) begin
            j = line_of(pend_addr);
            m_line_addr[j] = pend_addr;
            m_data[j]      = d;
            m_valid[j]     = !dropped;
            busy           = 1'b0;
         end
      end
      if (f) for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic fill(input logic [31:0] a, input logic [31:0] d, input int ack_dly, input int val_dly);
      step(a, 0, 0, 0, 0);
      repeat (ack_dly) step(a, 0, 0, 0, 0);
      step(a, 0, 1, 0, 0);
      repeat (val_dly) step(a, 0, 0, 0, 0);
      step(a, 0, 0, 1, d);
   endtask

   // Memory keeps answering during reset; none of it may land afterwards.
   task automatic do_reset(input int n);
      rst = 1'b1; flush = 1'b0;
      bus.mem2Icache_ack = 1'b0; bus.mem2Icache_valid = 1'b1; bus.mem2Icache_data = $urandom;
      repeat (n) begin
         #2;
         check_value("rst_req", {31'd0, bus.Icache2mem_req}, 32'd0);
         check_value("rst_hit", {31'd0, valid_out}, 32'd0);
         @(posedge clk); #1;
      end
      rst = 1'b0;
      model_clear();
      // Sweep previously used addresses under flush so no fill launches.
      flush = 1'b1;
      for (int k = 0; k < 8; k++) begin
         addr = 32'h40 << (k % 4) | (32'(k) << 2);
         #1;
         check_value("post_rst_hit", {31'd0, valid_out}, 32'd0);
      end
      check_value("post_rst_cnt", miss_count, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; bus.mem2Icache_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      bit f, ak, v;
      bus.mem2Icache_ack = 1'b0; bus.mem2Icache_valid = 1'b0; bus.mem2Icache_data = '0;
      model_clear();
      @(posedge clk); #1;
      do_reset(3);

      // Cold miss on 0x40, fastest memory.
      step(32'h40, 0, 0, 0, 0);
      #1 check_value("cold_req_addr", bus.Icache2mem_addr, 32'h40);
      step(32'h40, 0, 1, 0, 0);
      step(32'h40, 0, 0, 1, 32'hDEAD_BEEF);
      #1 check_value("cold_hit", {31'd0, valid_out}, 32'd1);
      check_value("cold_data", data_out, 32'hDEAD_BEEF);
      check_value("cold_cnt", miss_count, 32'd1);
      step(32'h41, 0, 0, 0, 0);

      // Conflict eviction on index 0.
      do_reset(2);
      fill(32'h0, 32'h1111_0000, 0, 0);
      step(32'h0, 0, 0, 0, 0);
      fill(32'h80, 32'h2222_0080, 1, 2);
      step(32'h80, 0, 0, 0, 0);
      fill(32'h0, 32'h3333_0000, 0, 0);
      #1 check_value("conflict_cnt", miss_count, 32'd3);
      step(32'h0, 0, 0, 0, 0);

      // Redirect while waiting: 0x100 fill completes, then 0x200 launches.
      step(32'h100, 0, 0, 0, 0);
      step(32'h100, 0, 1, 0, 0);
      step(32'h200, 0, 0, 0, 0);
      step(32'h200, 0, 0, 0, 0);
      step(32'h200, 0, 0, 1, 32'hCAFE_0100);
      step(32'h200, 0, 0, 0, 0);
      #1 check_value("redirect_req", {31'd0, bus.Icache2mem_req}, 32'd1);
      check_value("redirect_addr", bus.Icache2mem_addr, 32'h200);
      step(32'h200, 0, 1, 0, 0);
      step(32'h200, 0, 0, 1, 32'hCAFE_0200);
      step(32'h100, 0, 0, 0, 0);

      // Flush during WAIT drops the returning line.
      step(32'h40, 0, 0, 0, 0);
      step(32'h40, 0, 1, 0, 0);
      step(32'h40, 1, 0, 0, 0);
      step(32'h40, 0, 0, 1, 32'hBAD0_0040);
      #1 check_value("flush_drop_hit", {31'd0, valid_out}, 32'd0);
      step(32'h40, 0, 0, 0, 0);
      step(32'h40, 0, 1, 0, 0);
      step(32'h40, 0, 0, 1, 32'h600D_0040);
      step(32'h100, 0, 0, 0, 0);

      // Long ack stall, then reset while waiting.
      step(32'h300, 0, 0, 0, 0);
      repeat (10) step(32'h300 + ($urandom % 4) * 32'h80, 0, 0, 0, 0);
      step(32'h300, 0, 1, 0, 0);
      step(32'h300, 0, 0, 0, 0);
      do_reset(1);

      // Random traffic over a small address pool to mix hits and conflicts.
      a = 32'h0;
      repeat (3000) begin
         if ($urandom % 10 >= 6)
            a = (($urandom % 4) << 7) | (($urandom % 8) << 2) | ($urandom % 4);
         f  = ($urandom % 25) == 0;
         ak = busy && !acked && ($urandom % 2 == 0);
         v  = busy && ($urandom % 3 == 0);
         step(a, f, ak, v, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
